// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: state encodings, output
// decode and the default timing constants for a 50 MHz reference clock.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  localparam int DEF_RST_PULSE_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;  // 1 ms at 50 MHz
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_MAX_RETRIES         = 7;
  localparam int DEF_LOSS_CNT_W          = 8;

  typedef struct packed {
    logic pll_rst;
    logic user_rst_n;
    logic locked;
    logic fault;
  } sup_out_t;

  localparam sup_out_t RESET_OUTS = '{pll_rst: 1'b1, user_rst_n: 1'b0, locked: 1'b0, fault: 1'b0};

  // Width of a counter that walks 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Output levels that belong to each state; registered together with the state.
  function automatic sup_out_t decode_outputs(input state_t st);
    sup_out_t o;
    o = '{pll_rst: 1'b0, user_rst_n: 1'b0, locked: 1'b0, fault: 1'b0};
    case (st)
      ST_RST_PLL: o.pll_rst = 1'b1;
      ST_RUN: begin
        o.user_rst_n = 1'b1;
        o.locked     = 1'b1;
      end
      ST_FAULT: begin
        o.pll_rst = 1'b1;
        o.fault   = 1'b1;
      end
      default: o = o;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Two-flop synchronizer for a single asynchronous status bit; resets to 0.
module cdc_sync_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples the pre-edge value of its source, giving a true two-stage chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives the PLL reset, qualifies lock over a stability window, retries on
// timeout with a sticky fault, and gates the downstream reset on qualified lock.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int LOSS_CNT_W          = DEF_LOSS_CNT_W
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  pll_lock,
  input  logic                  retry_clr,
  output logic                  pll_rst,
  output logic                  user_rst_n,
  output logic                  locked,
  output logic                  fault,
  output logic [LOSS_CNT_W-1:0] loss_cnt,
  output logic [2:0]            state
);

  localparam int PULSE_W  = cnt_width(RST_PULSE_CYCLES);
  localparam int TMR_W    = cnt_width(LOCK_TIMEOUT_CYCLES);
  localparam int STABLE_W = cnt_width(LOCK_STABLE_CYCLES);
  localparam int RETRY_W  = cnt_width(MAX_RETRIES);

  localparam logic [PULSE_W-1:0]  PULSE_LAST  = PULSE_W'(RST_PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0]    TMR_LAST    = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0]  RETRY_LAST  = RETRY_W'(MAX_RETRIES - 1);

  state_t                state_q;
  sup_out_t              outs;
  logic                  lock_s;
  logic [PULSE_W-1:0]    pulse_cnt;
  logic [TMR_W-1:0]      timer;
  logic [STABLE_W-1:0]   stable_cnt;
  logic [RETRY_W-1:0]    retry_cnt;
  logic [LOSS_CNT_W-1:0] loss_cnt_q;

  cdc_sync_bit u_lock_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // Counters are cleared on entry to the state that uses them, so each
  // attempt starts from zero without a separate clear path.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_RST_PLL;
      outs       <= RESET_OUTS;
      pulse_cnt  <= '0;
      timer      <= '0;
      stable_cnt <= '0;
      retry_cnt  <= '0;
      loss_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_RST_PLL: begin
          if (pulse_cnt == PULSE_LAST) begin
            state_q   <= ST_WAIT_LOCK;
            outs      <= decode_outputs(ST_WAIT_LOCK);
            pulse_cnt <= '0;
            timer     <= '0;
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          timer <= timer + 1'b1;
          if (timer == TMR_LAST) begin
            if (retry_cnt == RETRY_LAST) begin
              state_q <= ST_FAULT;
              outs    <= decode_outputs(ST_FAULT);
            end else begin
              retry_cnt <= retry_cnt + 1'b1;
              state_q   <= ST_RST_PLL;
              outs      <= decode_outputs(ST_RST_PLL);
            end
          end else if (lock_s) begin
            state_q    <= ST_STABLE;
            outs       <= decode_outputs(ST_STABLE);
            stable_cnt <= '0;
          end
        end

        ST_STABLE: begin
          timer <= timer + 1'b1;
          // Qualification is checked first so it wins over a coincident timeout.
          if (lock_s && stable_cnt == STABLE_LAST) begin
            state_q   <= ST_RUN;
            outs      <= decode_outputs(ST_RUN);
            retry_cnt <= '0;
          end else if (timer == TMR_LAST) begin
            if (retry_cnt == RETRY_LAST) begin
              state_q <= ST_FAULT;
              outs    <= decode_outputs(ST_FAULT);
            end else begin
              retry_cnt <= retry_cnt + 1'b1;
              state_q   <= ST_RST_PLL;
              outs      <= decode_outputs(ST_RST_PLL);
            end
          end else if (!lock_s) begin
            state_q    <= ST_WAIT_LOCK;
            outs       <= decode_outputs(ST_WAIT_LOCK);
            stable_cnt <= '0;
          end else begin
            stable_cnt <= stable_cnt + 1'b1;
          end
        end

        ST_RUN: begin
          if (!lock_s) begin
            state_q <= ST_RST_PLL;
            outs    <= decode_outputs(ST_RST_PLL);
            if (loss_cnt_q != '1) begin
              loss_cnt_q <= loss_cnt_q + 1'b1;
            end
          end
        end

        ST_FAULT: begin
          if (retry_clr) begin
            state_q   <= ST_RST_PLL;
            outs      <= decode_outputs(ST_RST_PLL);
            retry_cnt <= '0;
          end
        end

        default: begin
          state_q   <= ST_RST_PLL;
          outs      <= decode_outputs(ST_RST_PLL);
          pulse_cnt <= '0;
        end
      endcase
    end
  end

  assign pll_rst    = outs.pll_rst;
  assign user_rst_n = outs.user_rst_n;
  assign locked     = outs.locked;
  assign fault      = outs.fault;
  assign loss_cnt   = loss_cnt_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short timing parameters;
// expected values are hand-derived edge counts.
module tb_pll_lock_supervisor;
  import pll_sup_pkg::*;

  localparam int RST_PULSE = 4;
  localparam int TIMEOUT   = 100;
  localparam int STABLE    = 8;
  localparam int RETRIES   = 3;
  localparam int LW        = 2;

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          pll_lock  = 1'b0;
  logic          retry_clr = 1'b0;
  logic          pll_rst;
  logic          user_rst_n;
  logic          locked;
  logic          fault;
  logic [LW-1:0] loss_cnt;
  logic [2:0]    state;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES    (RST_PULSE),
    .LOCK_TIMEOUT_CYCLES (TIMEOUT),
    .LOCK_STABLE_CYCLES  (STABLE),
    .MAX_RETRIES         (RETRIES),
    .LOSS_CNT_W          (LW)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .pll_lock   (pll_lock),
    .retry_clr  (retry_clr),
    .pll_rst    (pll_rst),
    .user_rst_n (user_rst_n),
    .locked     (locked),
    .fault      (fault),
    .loss_cnt   (loss_cnt),
    .state      (state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges and land 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] exp, input int budget);
    int n;
    n = 0;
    while (state !== exp && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, state, exp);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, state, ST_RST_PLL);
    check({tag, "_pll_rst"}, pll_rst, 1);
    check({tag, "_user_rst_n"}, user_rst_n, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_fault"}, fault, 0);
    check({tag, "_loss_cnt"}, loss_cnt, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int saw_stable;
    int saw_run;
    int early_rst;
    int fault_edge;
    int rises;
    int bad;
    logic prev_rst;

    tick(3);
    check_reset("por");

    // Reset release: pll_rst high for exactly RST_PULSE edges.
    sys_rst_n = 1'b1;
    for (int i = 1; i <= RST_PULSE; i++) begin
      tick(1);
      check($sformatf("pulse_e%0d", i), pll_rst, i < RST_PULSE);
    end
    check("pulse_state", state, ST_WAIT_LOCK);
    check("pulse_locked", locked, 0);

    // Lock arrives 20 cycles into WAIT_LOCK; RUN at edge 2+STABLE.
    tick(19);
    pll_lock = 1'b1;
    for (int k = 0; k <= STABLE + 2; k++) begin
      tick(1);
      check($sformatf("qual_locked_e%0d", k), locked, k >= STABLE + 2);
      if (k == 1) check("qual_wait_e1", state, ST_WAIT_LOCK);
      if (k == 2) check("qual_stable_e2", state, ST_STABLE);
    end
    check("qual_user_rst_n", user_rst_n, 1);
    check("qual_pll_rst", pll_rst, 0);
    check("qual_retry_cnt", dut.retry_cnt, 0);

    // Five lock losses with relock; counter saturates at 3.
    for (int d = 1; d <= 5; d++) begin
      pll_lock = 1'b0;
      tick(2);
      check($sformatf("loss%0d_e1_user_rst_n", d), user_rst_n, 1);
      tick(1);
      check($sformatf("loss%0d_e2_user_rst_n", d), user_rst_n, 0);
      check($sformatf("loss%0d_e2_pll_rst", d), pll_rst, 1);
      check($sformatf("loss%0d_e2_locked", d), locked, 0);
      check($sformatf("loss%0d_cnt", d), loss_cnt, (d < 3) ? d : 3);
      pll_lock = 1'b1;
      wait_state($sformatf("relock%0d", d), ST_RUN, 40);
    end

    // Asynchronous reset while in RUN.
    #2 sys_rst_n = 1'b0;
    #1 check_reset("rst_in_run");
    pll_lock = 1'b0;
    tick(2);
    sys_rst_n = 1'b1;
    tick(RST_PULSE);
    check("chat_start_state", state, ST_WAIT_LOCK);

    // Chatter (high 5, low 1): never qualifies, times out after TIMEOUT cycles.
    saw_stable = 0;
    saw_run    = 0;
    early_rst  = 0;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      pll_lock = (i % 6) != 5;
      tick(1);
      if (state == ST_STABLE) saw_stable = 1;
      if (state == ST_RUN) saw_run = 1;
      if (pll_rst) early_rst = 1;
    end
    check("chat_saw_stable", saw_stable, 1);
    check("chat_saw_run", saw_run, 0);
    check("chat_early_rst", early_rst, 0);
    pll_lock = 1'b0;
    tick(1);
    check("chat_timeout_pll_rst", pll_rst, 1);
    check("chat_timeout_state", state, ST_RST_PLL);
    check("chat_retry_cnt", dut.retry_cnt, 1);
    for (int j = 1; j <= RST_PULSE; j++) begin
      tick(1);
      check($sformatf("chat_pulse_e%0d", j), pll_rst, j < RST_PULSE);
    end

    // Asynchronous reset mid-STABLE clears retry state too.
    pll_lock = 1'b1;
    wait_state("to_stable", ST_STABLE, 10);
    #2 sys_rst_n = 1'b0;
    #1 check_reset("rst_in_stable");
    check("rst_in_stable_retry_cnt", dut.retry_cnt, 0);

    // Lock held low: three timeouts then FAULT at edge 3*(4+100).
    // A retry_clr pulse at edge 50 (WAIT_LOCK) must be ignored.
    pll_lock = 1'b0;
    tick(2);
    sys_rst_n  = 1'b1;
    fault_edge = 0;
    rises      = 0;
    prev_rst   = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      retry_clr = (n == 50);
      tick(1);
      if (fault && fault_edge == 0) fault_edge = n;
      if (fault_edge == 0 && pll_rst && !prev_rst) rises++;
      prev_rst = pll_rst;
      if (fault_edge != 0) break;
    end
    retry_clr = 1'b0;
    check("fault_edge", fault_edge, 3 * (RST_PULSE + TIMEOUT));
    check("fault_retry_rises", rises, 2);
    bad = 0;
    repeat (20) begin
      tick(1);
      if (!(pll_rst && fault && !locked && !user_rst_n && state == ST_FAULT)) bad++;
    end
    check("fault_steady", bad, 0);

    // retry_clr leaves FAULT into a fresh reset pulse, then WAIT_LOCK.
    retry_clr = 1'b1;
    tick(1);
    retry_clr = 1'b0;
    check("clr_fault", fault, 0);
    check("clr_pll_rst", pll_rst, 1);
    check("clr_state", state, ST_RST_PLL);
    check("clr_retry_cnt", dut.retry_cnt, 0);
    tick(RST_PULSE - 1);
    check("clr_pulse_last", pll_rst, 1);
    tick(1);
    check("clr_pulse_done", pll_rst, 0);
    check("clr_wait_state", state, ST_WAIT_LOCK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
